// File: rtl/dma_write_ring_engine.sv
// Purpose : AXI4 write-burst master that drains an FWFT FIFO into a circular buffer in DDR.
// Latency : AWVALID rises one cycle after the IDLE start decision, then W beats follow the AW handshake.
// Backpr. : one burst is outstanding at a time. AW and W hold until ready, B is awaited with BREADY=1, and the ring stalls while the host lags.
//
// Ports:
//   M_AXI_ACLK / M_AXI_ARESET                   clock, synchronous active-high reset
//   fifo_data / fifo_rd_count / fifo_ren        FWFT FIFO read side (pop = WVALID && WREADY)
//   cfg_enable / cfg_base_addr / cfg_ring_size  engine run, ring base and ring byte size
//   cfg_irq_thresh                              bursts per interrupt (0 = no interrupt)
//   host_rd_ptr                                 byte offset the host has consumed up to
//   irq_ack                                     clears irq
//   wr_ptr / irq / ring_stall / bresp_err       status outputs
//   M_AXI_AW* / M_AXI_W* / M_AXI_B*             AXI4 write channels
//
// Build option: define DMA_WR_ERR_HALT_EN to halt on a BRESP error (no wr_ptr advance)
// until cfg_enable toggles low->high. Left undefined, errors are only flagged (sticky).

module dma_write_ring_engine #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 256,
  parameter int CNT_W     = 16,
  parameter int ID_W      = 1
) (
  input  logic                  M_AXI_ACLK,
  input  logic                  M_AXI_ARESET,

  input  logic [DATA_W-1:0]     fifo_data,
  input  logic [CNT_W-1:0]      fifo_rd_count,
  output logic                  fifo_ren,

  input  logic                  cfg_enable,
  input  logic [ADDR_W-1:0]     cfg_base_addr,
  input  logic [ADDR_W-1:0]     cfg_ring_size,
  input  logic [15:0]           cfg_irq_thresh,
  input  logic [ADDR_W-1:0]     host_rd_ptr,
  input  logic                  irq_ack,

  output logic [ADDR_W-1:0]     wr_ptr,
  output logic                  irq,
  output logic                  ring_stall,
  output logic                  bresp_err,

  output logic [ID_W-1:0]       M_AXI_AWID,
  output logic [ADDR_W-1:0]     M_AXI_AWADDR,
  output logic [7:0]            M_AXI_AWLEN,
  output logic [2:0]            M_AXI_AWSIZE,
  output logic [1:0]            M_AXI_AWBURST,
  output logic [3:0]            M_AXI_AWCACHE,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,

  output logic [DATA_W-1:0]     M_AXI_WDATA,
  output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
  output logic                  M_AXI_WLAST,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,

  input  logic [ID_W-1:0]       M_AXI_BID,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY
);

  localparam int                BURST_BYTES_I = BURST_LEN * DATA_W / 8;
  localparam logic [ADDR_W-1:0] BURST_BYTES   = ADDR_W'(BURST_BYTES_I);
  localparam logic [CNT_W-1:0]  BURST_WORDS   = CNT_W'(BURST_LEN);
  localparam logic [8:0]        LAST_BEAT     = 9'(BURST_LEN - 1);
  localparam logic [7:0]        AWLEN_VAL     = 8'(BURST_LEN - 1);
  localparam logic [2:0]        AWSIZE_VAL    = 3'($clog2(DATA_W / 8));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   awaddr_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                wlast_q;
  logic                bready_q;
  logic [8:0]          beat_cnt;
  logic [15:0]         burst_cnt;
  logic [ADDR_W-1:0]   ring_size_q;  // ring size frozen for the burst in flight
  logic [15:0]         thresh_q;     // irq threshold frozen for the burst in flight
  logic                en_q;
  logic                restart_pend; // enable rose while a burst was still in flight
  logic                halted;

  // Combinational helpers
  logic [ADDR_W-1:0]   next_ptr;
  logic [ADDR_W-1:0]   wrap_ptr_cfg;
  logic [ADDR_W-1:0]   wrap_ptr_q;
  logic                ring_full;
  logic                count_ok;
  logic                en_rise;
  logic                start;
  logic [15:0]         burst_cnt_inc;
  logic                thresh_hit;
  logic                bresp_ok;
  logic                commit;
  logic                halt_set;
  logic                unused_bid;

  assign next_ptr      = wr_ptr + BURST_BYTES;
  assign wrap_ptr_cfg  = (next_ptr == cfg_ring_size) ? '0 : next_ptr;
  assign wrap_ptr_q    = (next_ptr == ring_size_q)   ? '0 : next_ptr;
  // One burst slot is always left empty, so wr_ptr == host_rd_ptr means the ring is empty.
  assign ring_full     = (wrap_ptr_cfg == host_rd_ptr);
  // A whole burst must already be in the FIFO, so WVALID never has to drop mid-burst.
  assign count_ok      = (fifo_rd_count >= BURST_WORDS);
  assign en_rise       = cfg_enable && !en_q;
  assign start         = cfg_enable && count_ok && !ring_full && !halted;
  assign burst_cnt_inc = burst_cnt + 16'd1;
  assign thresh_hit    = (thresh_q != 16'd0) && (burst_cnt_inc >= thresh_q);
  assign bresp_ok      = (M_AXI_BRESP == 2'b00);
  assign unused_bid    = ^M_AXI_BID;

`ifdef DMA_WR_ERR_HALT_EN
  // A failed burst is not committed and the engine parks until it is re-enabled.
  assign commit   = bresp_ok;
  assign halt_set = !bresp_ok;
`else
  // Errors are only recorded. The ring keeps streaming.
  assign commit   = 1'b1;
  assign halt_set = 1'b0;
`endif

  // Fixed AXI attributes
  assign M_AXI_AWID    = '0;
  assign M_AXI_AWLEN   = AWLEN_VAL;
  assign M_AXI_AWSIZE  = AWSIZE_VAL;
  assign M_AXI_AWBURST = 2'b01;   // INCR
  assign M_AXI_AWCACHE = 4'b0011; // bufferable, modifiable
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WSTRB   = '1;

  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = fifo_data;  // FWFT head word is presented directly
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_WLAST   = wlast_q;
  assign M_AXI_BREADY  = bready_q;
  assign fifo_ren      = wvalid_q && M_AXI_WREADY;

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state        <= IDLE;
      awaddr_q     <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      wlast_q      <= 1'b0;
      bready_q     <= 1'b0;
      beat_cnt     <= '0;
      burst_cnt    <= '0;
      ring_size_q  <= '0;
      thresh_q     <= '0;
      en_q         <= 1'b0;
      restart_pend <= 1'b0;
      halted       <= 1'b0;
      wr_ptr       <= '0;
      irq          <= 1'b0;
      ring_stall   <= 1'b0;
      bresp_err    <= 1'b0;
    end else begin
      en_q       <= cfg_enable;
      ring_stall <= (state == IDLE) && cfg_enable && count_ok && ring_full;

      // A threshold hit in RESP below overrides this clear in the same cycle.
      if (irq_ack) begin
        irq <= 1'b0;
      end

      // A rising enable mid-burst is remembered and applied once the burst retires.
      if (en_rise && (state != IDLE)) begin
        restart_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (en_rise || restart_pend) begin
            // The restart takes one idle cycle so the next decision sees the reloaded pointer.
            wr_ptr       <= '0;
            burst_cnt    <= '0;
            halted       <= 1'b0;
            restart_pend <= 1'b0;
          end else if (start) begin
            awaddr_q    <= cfg_base_addr + wr_ptr;
            ring_size_q <= cfg_ring_size;
            thresh_q    <= cfg_irq_thresh;
            awvalid_q   <= 1'b1;
            state       <= ADDR;
          end
        end

        ADDR: begin
          if (M_AXI_AWREADY) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            beat_cnt  <= '0;
            wlast_q   <= (BURST_LEN == 1);
            state     <= DATA;
          end
        end

        DATA: begin
          if (M_AXI_WREADY) begin
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state    <= RESP;
            end else begin
              beat_cnt <= beat_cnt + 9'd1;
              wlast_q  <= ((beat_cnt + 9'd1) == LAST_BEAT);
            end
          end
        end

        RESP: begin
          if (M_AXI_BVALID) begin
            bready_q <= 1'b0;
            state    <= IDLE;
            if (!bresp_ok) begin
              bresp_err <= 1'b1;
            end
            if (halt_set) begin
              halted <= 1'b1;
            end
            if (commit) begin
              wr_ptr <= wrap_ptr_q;
              if (thresh_hit) begin
                irq       <= 1'b1;
                burst_cnt <= '0;
              end else begin
                burst_cnt <= burst_cnt_inc;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_write_ring_engine.sv
// Purpose : directed checks of dma_write_ring_engine (DATA_W=64, BURST_LEN=16, 0x80-byte bursts).
// Latency : one FWFT FIFO model, one AXI slave model, and a negedge monitor feeding the checks.
// Backpr. : the slave model can randomise AWREADY and WREADY.

module tb_dma_write_ring_engine;

  localparam int          BL   = 16;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] fifo_data;
  logic [15:0] fifo_rd_count;
  logic        fifo_ren;
  logic        cfg_enable;
  logic [31:0] cfg_base_addr;
  logic [31:0] cfg_ring_size;
  logic [15:0] cfg_irq_thresh;
  logic [31:0] host_rd_ptr;
  logic        irq_ack;
  logic [31:0] wr_ptr;
  logic        irq;
  logic        ring_stall;
  logic        bresp_err;
  logic [0:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [0:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  always #5 clk = ~clk;

  dma_write_ring_engine #(
    .ADDR_W(32), .DATA_W(64), .BURST_LEN(BL), .CNT_W(16), .ID_W(1)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .fifo_data(fifo_data), .fifo_rd_count(fifo_rd_count), .fifo_ren(fifo_ren),
    .cfg_enable(cfg_enable), .cfg_base_addr(cfg_base_addr), .cfg_ring_size(cfg_ring_size),
    .cfg_irq_thresh(cfg_irq_thresh), .host_rd_ptr(host_rd_ptr), .irq_ack(irq_ack),
    .wr_ptr(wr_ptr), .irq(irq), .ring_stall(ring_stall), .bresp_err(bresp_err),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWCACHE(awcache), .M_AXI_AWPROT(awprot),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready),
    .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
  );

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- FIFO model ----------------
  int pushed = 0;  // written by the stimulus process only
  int pops   = 0;  // written by the monitor only

  function automatic logic [63:0] pat(input int n);
    return {32'hD00D_0000 + 32'(n), 32'(n) ^ 32'h5A5A_5A5A};
  endfunction

  assign fifo_data     = pat(pops);
  assign fifo_rd_count = 16'(pushed - pops);
  assign bid           = 1'b0;

  // ---------------- monitor (negedge: values hold until the next posedge) ----------------
  int          aw_count = 0;
  int          w_hs = 0;
  int          b_count = 0;
  int          beat_in_burst = 0;
  int          wlast_bad = 0;
  int          data_bad = 0;
  logic [31:0] last_awaddr = '0;
  logic [7:0]  last_awlen = '0;
  logic [2:0]  last_awsize = '0;
  logic [8:0]  last_attr = '0;
  logic        last_hs_flag = 1'b0;
  logic        b_hs_flag = 1'b0;

  always @(negedge clk) begin
    last_hs_flag = 1'b0;
    b_hs_flag    = 1'b0;
    if (awvalid && awready) begin
      aw_count++;
      last_awaddr = awaddr;
      last_awlen  = awlen;
      last_awsize = awsize;
      last_attr   = {awburst, awcache, awprot};
    end
    if (wvalid && wready) begin
      w_hs++;
      if (wdata !== pat(pops) || wstrb !== 8'hFF) data_bad++;
      if (wlast !== (beat_in_burst == BL - 1)) wlast_bad++;
      if (beat_in_burst == BL - 1) beat_in_burst = 0;
      else beat_in_burst++;
      if (wlast) last_hs_flag = 1'b1;
    end
    if (fifo_ren) pops++;
    if (bvalid && bready) begin
      b_count++;
      b_hs_flag = 1'b1;
    end
    if (rst) beat_in_burst = 0;
  end

  // ---------------- AXI slave model (drives #1 after posedge) ----------------
  logic rand_rdy = 1'b0;
  int   err_burst = -1;  // 1-based B index answered with SLVERR
  int   b_pending = 0;

  initial begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bresp   = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        bvalid    = 1'b0;
        b_pending = 0;
        awready   = 1'b0;
        wready    = 1'b0;
      end else begin
        if (b_hs_flag) bvalid = 1'b0;
        if (last_hs_flag) b_pending++;
        if (!bvalid && b_pending > 0) begin
          bvalid = 1'b1;
          bresp  = (b_count + 1 == err_burst) ? 2'b10 : 2'b00;
          b_pending--;
        end
        awready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        wready  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int          nb = 0;       // bursts expected to have completed
  logic [31:0] exp_ptr = '0;

  task automatic wait_b(input int target, input bit ack);
    int n = 0;
    while (b_count < target && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (b_count < target) check("bresp_timeout", 64'(b_count), 64'(target));
    if (ack) irq_ack = 1'b1;  // lands on the same edge as the BRESP handshake
    @(negedge clk);
    #1;
    irq_ack = 1'b0;
  endtask

  task automatic run_burst(input bit ack);
    host_rd_ptr = exp_ptr;
    pushed += BL;
    nb++;
    wait_b(nb, ack);
    exp_ptr = (exp_ptr + 32'h80 == cfg_ring_size) ? 32'h0 : exp_ptr + 32'h80;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic restart();
    cfg_enable = 1'b0;
    cycles(2);
    host_rd_ptr = 32'h0;
    exp_ptr     = 32'h0;
    cfg_enable  = 1'b1;
    cycles(2);
  endtask

  task automatic ack_pulse();
    irq_ack = 1'b1;
    cycles(1);
    irq_ack = 1'b0;
  endtask

  logic [31:0] t2_addr [8] = '{32'h000, 32'h080, 32'h100, 32'h180,
                               32'h000, 32'h080, 32'h100, 32'h180};
  logic [31:0] t2_ptr  [8] = '{32'h080, 32'h100, 32'h180, 32'h000,
                               32'h080, 32'h100, 32'h180, 32'h000};

  initial begin
    rst            = 1'b1;
    cfg_enable     = 1'b0;
    cfg_base_addr  = BASE;
    cfg_ring_size  = 32'h400;
    cfg_irq_thresh = 16'd0;
    host_rd_ptr    = 32'h0;
    irq_ack        = 1'b0;
    cycles(3);

    // Reset state
    check("rst_wr_ptr", wr_ptr, 0);
    check("rst_outs", {awvalid, wvalid, wlast, bready, fifo_ren, irq, ring_stall, bresp_err}, 0);
    rst = 1'b0;
    cycles(1);

    // 1: single burst
    cfg_enable = 1'b1;
    cycles(2);
    run_burst(1'b0);
    check("t1_awaddr", last_awaddr, 32'h1000_0000);
    check("t1_awlen", last_awlen, 15);
    check("t1_awsize", last_awsize, 3);
    check("t1_aw_attr", last_attr, {2'b01, 4'b0011, 3'b000});
    check("t1_beats", w_hs, 16);
    check("t1_wlast_pos", wlast_bad, 0);
    check("t1_wr_ptr", wr_ptr, 32'h080);

    // 2: 0x200 ring, host keeps up, wrap after 0x180
    cfg_ring_size = 32'h200;
    restart();
    for (int i = 0; i < 8; i++) begin
      run_burst(1'b0);
      check($sformatf("t2_awaddr_%0d", i), last_awaddr, BASE + t2_addr[i]);
      check($sformatf("t2_wr_ptr_%0d", i), wr_ptr, t2_ptr[i]);
    end

    // 3: host stuck at 0, the ring fills at wr_ptr=0x180
    host_rd_ptr = 32'h0;
    pushed += 4 * BL;
    nb += 3;
    wait_b(nb, 1'b0);
    cycles(10);
    check("t3_wr_ptr", wr_ptr, 32'h180);
    check("t3_stall", ring_stall, 1);
    check("t3_no_aw", aw_count, nb);
    host_rd_ptr = 32'h080;
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 2 && !seen; i++) begin
        cycles(1);
        if (awvalid) seen = 1'b1;
      end
      check("t3_release_aw", seen, 1);
    end
    check("t3_stall_clear", ring_stall, 0);
    nb++;
    wait_b(nb, 1'b0);
    check("t3_awaddr", last_awaddr, BASE + 32'h180);
    check("t3_wrap", wr_ptr, 32'h0);

    // 4: interrupt every 3 bursts, ack collides with the 6th BRESP
    cfg_irq_thresh = 16'd3;
    restart();
    run_burst(1'b0);
    run_burst(1'b0);
    check("t4_irq_b2", irq, 0);
    run_burst(1'b0);
    check("t4_irq_b3", irq, 1);
    ack_pulse();
    check("t4_irq_ack", irq, 0);
    run_burst(1'b0);
    run_burst(1'b0);
    check("t4_irq_b5", irq, 0);
    run_burst(1'b1);
    check("t4_irq_ack_collide", irq, 1);
    ack_pulse();
    check("t4_irq_ack2", irq, 0);

    // 5: SLVERR on the second burst
    cfg_irq_thresh = 16'd0;
    restart();
    err_burst = nb + 2;
    run_burst(1'b0);
    check("t5_err_b1", bresp_err, 0);
    check("t5_ptr_b1", wr_ptr, 32'h080);
    run_burst(1'b0);
    check("t5_err_b2", bresp_err, 1);
`ifdef DMA_WR_ERR_HALT_EN
    check("t5_halt_ptr", wr_ptr, 32'h080);
    host_rd_ptr = 32'h080;
    pushed += BL;
    cycles(20);
    check("t5_halt_no_aw", aw_count, nb);
    restart();
    nb++;
    wait_b(nb, 1'b0);
    check("t5_rearm_awaddr", last_awaddr, BASE);
    check("t5_rearm_ptr", wr_ptr, 32'h080);
`else
    check("t5_ptr_b2", wr_ptr, 32'h100);
    run_burst(1'b0);
    check("t5_b3_awaddr", last_awaddr, BASE + 32'h100);
    check("t5_ptr_b3", wr_ptr, 32'h180);
`endif
    check("t5_err_sticky", bresp_err, 1);
    err_burst = -1;

    // 6: random AWREADY/WREADY, then reset in the middle of a data phase
    rand_rdy = 1'b1;
    restart();
    run_burst(1'b0);
    run_burst(1'b0);
    check("t6_ptr", wr_ptr, 32'h100);
    host_rd_ptr = 32'h100;
    pushed += BL;
    begin
      logic hit = 1'b0;
      for (int i = 0; i < 1000 && !hit; i++) begin
        cycles(1);
        if (wvalid && beat_in_burst >= 5) hit = 1'b1;
      end
      if (!hit) check("t6_middata_tmo", hit, 1);
    end
    rst = 1'b1;
    cycles(1);
    check("t6_rst_outs", {awvalid, wvalid, wlast, bready, fifo_ren, irq, ring_stall, bresp_err}, 0);
    check("t6_rst_ptr", wr_ptr, 0);
    check("t6_pops_eq_hs", pops, w_hs);
    rst = 1'b0;
    cycles(2);
    check("all_wdata", data_bad, 0);
    check("all_wlast", wlast_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
